// File: rtl/ex_wb_stage_if.sv
// rtl/ex_wb_stage_if.sv - execute-side inputs and writeback/redirect outputs of ex_wb_stage
interface ex_wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 6
);
    logic              stall;
    logic              flush;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_result;
    logic [DATA_W-1:0] ex_readData;
    logic              ex_zero;
    logic              ex_neg;
    logic              ex_memToReg;
    logic              ex_regWrite;
    logic              ex_brz;
    logic              ex_brn;
    logic              ex_jump;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] ex_target;
    logic              wb_we;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              pc_redirect;
    logic [DATA_W-1:0] pc_target;
    logic              a_busy;
    logic [REG_AW-1:0] a_rd;

    modport master (
        output stall, flush, ex_valid, ex_result, ex_readData, ex_zero, ex_neg,
               ex_memToReg, ex_regWrite, ex_brz, ex_brn, ex_jump, ex_rd, ex_target,
        input  wb_we, wb_addr, wb_data, pc_redirect, pc_target, a_busy, a_rd
    );

    modport slave (
        input  stall, flush, ex_valid, ex_result, ex_readData, ex_zero, ex_neg,
               ex_memToReg, ex_regWrite, ex_brz, ex_brn, ex_jump, ex_rd, ex_target,
        output wb_we, wb_addr, wb_data, pc_redirect, pc_target, a_busy, a_rd
    );
endinterface

// File: rtl/ex_wb_stage.sv
// rtl/ex_wb_stage.sv - two-stage capture/writeback pipeline with load hold and branch redirect
module ex_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 6
) (
    input logic           clock,
    input logic           resetn,
    ex_wb_stage_if.slave  bus
);
    logic              a_valid, a_mem, a_rw, a_brz, a_brn, a_jump, a_zero, a_neg;
    logic [DATA_W-1:0] a_result, a_target, ld_hold;
    logic [REG_AW-1:0] a_rd_q;
    logic              ld_done;
    logic              b_valid, b_wr;
    logic [REG_AW-1:0] b_addr;
    logic [DATA_W-1:0] b_data, pc_tgt;
    logic              redirect;
    logic              taken, wr_new;
    logic [DATA_W-1:0] a_data;

    always_comb begin
        taken  = a_jump | (a_brz & a_zero) | (a_brn & a_neg);
        wr_new = a_valid & a_rw & (a_rd_q != '0);
        a_data = a_mem ? (ld_done ? ld_hold : bus.ex_readData) : a_result;
    end

    // Stage A: flush wins over stall; load data is latched once so a stall cannot corrupt it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            a_valid  <= 1'b0;
            a_mem    <= 1'b0;
            a_rw     <= 1'b0;
            a_brz    <= 1'b0;
            a_brn    <= 1'b0;
            a_jump   <= 1'b0;
            a_zero   <= 1'b0;
            a_neg    <= 1'b0;
            a_result <= '0;
            a_target <= '0;
            a_rd_q   <= '0;
            ld_hold  <= '0;
            ld_done  <= 1'b0;
        end else begin
            if (!bus.stall) begin
                a_valid  <= bus.ex_valid & ~bus.flush;
                a_mem    <= bus.ex_memToReg;
                a_rw     <= bus.ex_regWrite;
                a_brz    <= bus.ex_brz;
                a_brn    <= bus.ex_brn;
                a_jump   <= bus.ex_jump;
                a_zero   <= bus.ex_zero;
                a_neg    <= bus.ex_neg;
                a_result <= bus.ex_result;
                a_target <= bus.ex_target;
                a_rd_q   <= bus.ex_rd;
            end else if (bus.flush) begin
                a_valid <= 1'b0;
            end

            if (!bus.stall || bus.flush) begin
                ld_done <= 1'b0;
            end else if (a_valid && a_mem && !ld_done) begin
                ld_hold <= bus.ex_readData;
                ld_done <= 1'b1;
            end
        end
    end

    // Stage B: a stall drops B so a held write is issued only once; wb_addr/wb_data move only on real writes.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            b_valid  <= 1'b0;
            b_wr     <= 1'b0;
            b_addr   <= '0;
            b_data   <= '0;
            redirect <= 1'b0;
            pc_tgt   <= '0;
        end else if (!bus.stall) begin
            b_valid  <= a_valid;
            b_wr     <= a_rw & (a_rd_q != '0);
            redirect <= a_valid & taken;
            if (wr_new) begin
                b_addr <= a_rd_q;
                b_data <= a_data;
            end
            if (a_valid && taken) begin
                pc_tgt <= a_target;
            end
        end else begin
            b_valid  <= 1'b0;
            redirect <= 1'b0;
        end
    end

    assign bus.wb_we       = b_valid & b_wr;
    assign bus.wb_addr     = b_addr;
    assign bus.wb_data     = b_data;
    assign bus.pc_redirect = redirect;
    assign bus.pc_target   = pc_tgt;
    assign bus.a_busy      = a_valid;
    assign bus.a_rd        = a_rd_q;
endmodule

// File: doc/ex_wb_stage.md
EX_WB_STAGE -- requirements
Module: ex_wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath and PC width.
REQ-002 SHALL have parameter REG_AW, default 6, register-address width.
REQ-003 SHALL have clock: input, 1, single rising-edge clock for all state.
REQ-004 SHALL have resetn: input, 1, asynchronous active-low reset.
REQ-005 SHALL have stall: input, 1, hold both stages.
REQ-006 SHALL have flush: input, 1, discard the instruction entering stage A.
REQ-007 SHALL have ex_valid: input, 1, execute stage presents an instruction.
REQ-008 SHALL have ex_result: input, DATA_W, ALU result.
REQ-009 SHALL have ex_readData: input, DATA_W, synchronous data-memory output, valid one cycle after the load is presented.
REQ-010 SHALL have ex_zero and ex_neg: input, 1 each, ALU flags.
REQ-011 SHALL have ex_memToReg, ex_regWrite, ex_brz, ex_brn, ex_jump: input, 1 each, decoded control.
REQ-012 SHALL have ex_rd: input, REG_AW, destination register; ex_target: input, DATA_W, branch/jump target.
REQ-013 SHALL have wb_we: output, 1; wb_addr: output, REG_AW; wb_data: output, DATA_W; these are the register-file write port.
REQ-014 SHALL have pc_redirect: output, 1; pc_target: output, DATA_W; these form the fetch redirect pulse.
REQ-015 SHALL have a_busy: output, 1, and a_rd: output, REG_AW; these expose stage-A occupancy for hazard detection.

Function
REQ-016 SHALL implement two register stages, A (capture) and B (writeback), giving 2-cycle latency from ex_valid to wb_we.
REQ-017 Stage A, on a clock edge with stall=0, SHALL load A_valid from (ex_valid & ~flush) and capture all ex_* fields except ex_readData.
REQ-018 SHALL give flush priority over stall: flush=1 clears A_valid on that edge even when stall=1.
REQ-019 SHALL capture ex_readData into an ld_hold register on the first cycle a load (A_memToReg=1) occupies stage A, and set ld_done=1 at that point.
REQ-020 While ld_done=1, SHALL ignore further ex_readData changes, so a stall cannot corrupt load data.
REQ-021 On an edge with stall=0, SHALL transfer A to B with B_data = A_memToReg ? (ld_done ? ld_hold : ex_readData) : A_result.
REQ-022 SHALL clear ld_done on every A-to-B transfer.
REQ-023 SHALL drive wb_we = B_valid & B_regWrite & (B_addr != 0); a write to register 0 SHALL never be issued.
REQ-024 SHALL keep wb_addr and wb_data as registered values and SHALL leave them unchanged while wb_we=0.
REQ-025 When wb_we=1 and stall=1, SHALL hold the write for one cycle only: B_valid is cleared after one write cycle so no duplicate write occurs.
REQ-026 On an A-to-B transfer with A_valid & (A_jump | A_brz&A_zero | A_brn&A_neg), SHALL assert pc_redirect for exactly one cycle and drive pc_target = A_target.
REQ-027 SHALL return pc_redirect to 0 on the next edge regardless of stall.
REQ-028 When jump and brz/brn are set together, SHALL resolve them as taken (OR); the target is unchanged.
REQ-029 SHALL drive a_busy = A_valid and a_rd = A_rd combinationally from stage A.
REQ-030 SHALL contain no arithmetic; all data SHALL pass unmodified at DATA_W bits.

Reset
REQ-031 resetn=0 SHALL immediately clear A_valid, B_valid, ld_done, wb_we, pc_redirect and a_busy.
REQ-032 resetn=0 SHALL immediately zero wb_addr, wb_data, pc_target, a_rd and ld_hold.
REQ-033 An asserted reset SHALL discard in-flight instructions mid-operation; no write or redirect SHALL appear after deassertion without new ex_valid.
REQ-034 Reset deassertion SHALL take effect at the next rising edge, with state resuming from the empty condition.

Verification
REQ-035 SHALL cover ALU op: ex_valid, regWrite=1, rd=5, result=0x0000001E at cycle 0 -> wb_we=1, wb_addr=5, wb_data=0x1E at cycle 2.
REQ-036 SHALL cover load with stall: load rd=3 at cycle 0; ex_readData=19 at cycle 1, changed to 0xDEAD at cycle 2; stall held cycles 1-3 -> single wb_we with wb_data=19.
REQ-037 SHALL cover r0 suppression: regWrite=1, rd=0, result=7 -> wb_we never asserts.
REQ-038 SHALL cover branches: brz=1, zero=1, target=0x40 -> pc_redirect=1 for exactly one cycle with pc_target=0x40; brn=1, neg=0 -> no redirect.
REQ-039 SHALL cover stall+flush: flush=1 and stall=1 on the same edge with ex_valid=1 -> a_busy=0 and the instruction is never written.
REQ-040 SHALL cover reset mid-flight: resetn pulsed low while A and B are both valid -> all outputs 0 immediately and no write after release.
